// File: rtl/wishbone_arbiter_2m.sv
// Two-master, one-slave Wishbone classic arbiter for the debug bus.
// m0 is the JTAG-driven wishbone_master and m1 is a secondary requester such
// as a UART command bridge. Both share the single wishbone_dm_slave.
// Ownership is granted to one master at a time. When both masters contend,
// the grant alternates between them. A watchdog ends any stalled strobe with
// an error, so neither master can lock up the slave.
`timescale 1ns/1ps

module wishbone_arbiter_2m #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 64,
   // Legal range is 2..65535, so the limit fits the 16-bit watchdog counter.
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  m0_cyc_i,
   input  logic                  m0_stb_i,
   input  logic                  m0_we_i,
   input  logic [ADDR_WIDTH-1:0] m0_addr_i,
   input  logic [DATA_WIDTH-1:0] m0_data_i,
   output logic [DATA_WIDTH-1:0] m0_data_o,
   output logic                  m0_ack_o,
   output logic                  m0_err_o,

   input  logic                  m1_cyc_i,
   input  logic                  m1_stb_i,
   input  logic                  m1_we_i,
   input  logic [ADDR_WIDTH-1:0] m1_addr_i,
   input  logic [DATA_WIDTH-1:0] m1_data_i,
   output logic [DATA_WIDTH-1:0] m1_data_o,
   output logic                  m1_ack_o,
   output logic                  m1_err_o,

   output logic                  s_cyc_o,
   output logic                  s_stb_o,
   output logic                  s_we_o,
   output logic [ADDR_WIDTH-1:0] s_addr_o,
   output logic [DATA_WIDTH-1:0] s_data_o,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   input  logic                  s_ack_i,

   output logic [1:0]            gnt_o,
   output logic                  timeout_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   // The watchdog fires when the counter reaches TIMEOUT_CYCLES-1 with no ack.
   // That fire cycle is therefore the TIMEOUT_CYCLES-th stalled strobe cycle.
   localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES - 1);

   state_t                state;
   state_t                state_next;
   logic                  last_owner;
   logic                  last_owner_next;
   logic [15:0]           wdog_cnt;
   logic [15:0]           wdog_next;

   logic                  owner_cyc;
   logic                  owner_stb;
   logic                  owner_we;
   logic [ADDR_WIDTH-1:0] owner_addr;
   logic [DATA_WIDTH-1:0] owner_data;
   logic                  wdog_fire;
   logic                  ack_fwd;

   // State, fairness pointer and watchdog register.
   // last_owner resets to m1, so m0 wins the first contention after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         wdog_cnt   <= 16'd0;
      end else begin
         state      <= state_next;
         last_owner <= last_owner_next;
         wdog_cnt   <= wdog_next;
      end
   end

   // Arbitration and release.
   // IDLE always lasts at least one cycle, so ownership never passes
   // directly from one master to the other.
   always_comb begin
      state_next      = state;
      last_owner_next = last_owner;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               if (last_owner) begin
                  state_next      = OWN0;
                  last_owner_next = 1'b0;
               end else begin
                  state_next      = OWN1;
                  last_owner_next = 1'b1;
               end
            end else if (m0_cyc_i) begin
               state_next      = OWN0;
               last_owner_next = 1'b0;
            end else if (m1_cyc_i) begin
               state_next      = OWN1;
               last_owner_next = 1'b1;
            end
         end
         OWN0: begin
            if (!m0_cyc_i) begin
               state_next = IDLE;
            end
         end
         OWN1: begin
            if (!m1_cyc_i) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Select the owner's request signals. Everything is zero in IDLE.
   // The owner's strobe counts only while its cyc is up, so an abandoned
   // cycle drops s_cyc_o and s_stb_o in the same cycle.
   always_comb begin
      owner_cyc  = 1'b0;
      owner_stb  = 1'b0;
      owner_we   = 1'b0;
      owner_addr = '0;
      owner_data = '0;
      case (state)
         OWN0: begin
            owner_cyc  = m0_cyc_i;
            owner_stb  = m0_cyc_i & m0_stb_i;
            owner_we   = m0_we_i;
            owner_addr = m0_addr_i;
            owner_data = m0_data_i;
         end
         OWN1: begin
            owner_cyc  = m1_cyc_i;
            owner_stb  = m1_cyc_i & m1_stb_i;
            owner_we   = m1_we_i;
            owner_addr = m1_addr_i;
            owner_data = m1_data_i;
         end
         default: begin
            owner_cyc = 1'b0;
         end
      endcase
   end

   // Watchdog fire detection.
   // An ack arriving in the same cycle wins, so the watchdog does not fire.
   always_comb begin
      wdog_fire = owner_stb & ~s_ack_i & (wdog_cnt == WDOG_LIMIT);
   end

   // Watchdog count.
   // The counter runs only while the owner strobes without an ack.
   // It clears on ack, on strobe low, in IDLE, and when it fires.
   always_comb begin
      wdog_next = wdog_cnt + 16'd1;
      if ((state == IDLE) || !owner_stb || s_ack_i || wdog_fire) begin
         wdog_next = 16'd0;
      end
   end

   // Slave-side outputs.
   // The strobe is withheld during a watchdog fire, so the slave never sees
   // that cycle as a transfer.
   always_comb begin
      s_cyc_o  = owner_cyc;
      s_stb_o  = owner_stb & ~wdog_fire;
      s_we_o   = owner_we;
      s_addr_o = owner_addr;
      s_data_o = owner_data;
   end

   // Termination back to the masters.
   // An ack is forwarded only against a live strobe, so a stray slave ack is
   // dropped. Only the owner ever sees ack or err.
   always_comb begin
      ack_fwd   = s_ack_i & s_stb_o;
      m0_ack_o  = ack_fwd   & (state == OWN0);
      m1_ack_o  = ack_fwd   & (state == OWN1);
      m0_err_o  = wdog_fire & (state == OWN0);
      m1_err_o  = wdog_fire & (state == OWN1);
      timeout_o = wdog_fire;
   end

   // Read data is broadcast to both masters, which qualify it with ack.
   // It is held at zero while reset is asserted.
   always_comb begin
      m0_data_o = rst_n ? s_data_i : '0;
      m1_data_o = rst_n ? s_data_i : '0;
   end

   // One-hot grant view of the current owner.
   always_comb begin
      gnt_o = 2'b00;
      case (state)
         OWN0:    gnt_o = 2'b01;
         OWN1:    gnt_o = 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: doc/wishbone_arbiter_2m.md
Name: wishbone_arbiter_2m

Overview:
- Two-master, one-slave Wishbone classic arbiter.
- Shares the debug Wishbone bus between the JTAG-TAP-driven wishbone_master (m0) and a second requester (m1), e.g. a UART command bridge. The shared slave is wishbone_dm_slave.
- Grants one owner at a time, round-robin when both masters request.
- A watchdog terminates stalled cycles with an error so neither master can hang the bus.

Parameters:
- ADDR_WIDTH, 32, width of the address buses.
- DATA_WIDTH, 64, width of the data buses.
- TIMEOUT_CYCLES, 1023, number of consecutive owner stb cycles without ack before err is returned. Legal range 2..65535.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls.
- m0_addr_i  in  ADDR_WIDTH  master 0 address.
- m0_data_i  in  DATA_WIDTH  master 0 write data.
- m0_data_o  out  DATA_WIDTH  read data to master 0.
- m0_ack_o, m0_err_o  out  1 each  master 0 termination.
- m1_* (same set as m0_*)  master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave controls.
- s_addr_o  out  ADDR_WIDTH  slave address.
- s_data_o  out  DATA_WIDTH  slave write data.
- s_data_i  in  DATA_WIDTH  slave read data.
- s_ack_i  in  1  slave acknowledge.
- gnt_o  out  2  one-hot current owner: bit0 = m0, bit1 = m1, 00 = idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, gnt_o = 00, last_owner = 1 (so m0 wins the first contention), watchdog = 0.
  - All s_* outputs, m*_ack_o, m*_err_o and timeout_o = 0; m*_data_o = 0.
  - Reset mid-transaction drops s_cyc_o/s_stb_o immediately. No ack or err is delivered for the aborted cycle.
- States:
  - IDLE: arbitrate.
  - OWN0: m0 owns the bus.
  - OWN1: m1 owns the bus.
- Arbitration, in IDLE, evaluated at the clock edge:
  - Only m0_cyc_i high -> OWN0. Only m1_cyc_i high -> OWN1.
  - Both high -> grant the master that is not last_owner; last_owner updates on grant.
  - Neither high -> stay in IDLE.
- Grant latency: cyc asserted in the cycle ending at edge N; gnt_o and s_cyc_o are high from edge N onward (one cycle latency).
- Hold: OWNx persists while mx_cyc_i is high. Any number of back-to-back stb transfers is allowed under one cyc.
- Release:
  - mx_cyc_i low in OWNx -> IDLE at the next edge.
  - IDLE always lasts at least one cycle, so there is no direct OWN0 -> OWN1 transition. Fairness comes from last_owner.
- Muxing (combinational from gnt_o):
  - s_cyc_o/s_stb_o/s_we_o/s_addr_o/s_data_o = owner's signals. All zero in IDLE.
  - mx_ack_o = s_ack_i & s_stb_o & owner==x.
  - Non-owner ack_o/err_o = 0.
  - m0_data_o and m1_data_o both = s_data_i (broadcast). Masters qualify read data with ack.
- s_ack_i while s_stb_o is low: ignored, never forwarded.
- Watchdog:
  - 16-bit counter.
  - Increments each cycle the owner's stb is high and s_ack_i is low.
  - Clears on s_ack_i, on stb low, and in IDLE.
  - Fires in the cycle the counter equals TIMEOUT_CYCLES-1 with no ack. In that cycle:
    - mx_err_o = 1 for one cycle;
    - s_stb_o is forced 0;
    - timeout_o pulses;
    - the counter clears.
  - Ownership is retained until the master drops cyc.
  - Ack and timeout in the same cycle: ack wins, no err, no timeout_o.
- Master drops cyc with stb pending (abandon): the slave sees s_cyc_o/s_stb_o fall in the same cycle; state goes to IDLE.
- ack_o and err_o are never both high.

Test Plan:
- Single master: m0 reads addr 0x00000011, slave acks 2 cycles after s_stb_o -> gnt_o = 01 one cycle after m0_cyc_i; m0_ack_o coincides with s_ack_i; m0_data_o = 0x0000_0000_DEAD_BEEF; m1_ack_o stays 0.
- Contention from reset: m0 and m1 raise cyc in the same cycle -> m0 granted first. After m0 drops cyc: exactly one IDLE cycle, then gnt_o = 10. Repeat with both requesting again -> m0 granted (alternation).
- Back-to-back: m1 holds cyc across 3 stb/ack writes (data 0x1, 0x2, 0x3) while m0 requests -> all three reach the slave with s_we_o = 1; m0 waits until m1 releases.
- Timeout: TIMEOUT_CYCLES = 8, slave never acks -> m0_err_o and timeout_o pulse on the 8th stb cycle; s_stb_o is low that cycle; no m0_ack_o. Variant with ack on the 8th cycle -> ack only, no err.
- Async reset mid-transaction: assert rst_n low between clock edges during OWN1 -> s_cyc_o, gnt_o and ack/err drop immediately. After release, a simultaneous request grants m0.
- Stray ack: s_ack_i pulses in IDLE and while the owner's stb is low -> no m*_ack_o is generated and the watchdog is unaffected.
